// File: rtl/mem_arb_pkg.sv
// Shared definitions for the icemem port arbiter: FSM encoding, port indices
// and default memory geometry (kept in step with icemem).
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: combinational one-hot pick, registered pointer.
// The pointer only moves on contention, or is pinned to port 1 when asked.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_enable,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       pin,
  output logic [1:0] pick,
  output logic       win
);
  logic ptr;

  always_comb begin
    pick = 2'b00;
    win  = ptr;
    if (req == 2'b11) begin
      win  = ptr;
      pick = ptr ? 2'b10 : 2'b01;
    end else if (req[1]) begin
      win  = 1'b1;
      pick = 2'b10;
    end else if (req[0]) begin
      win  = 1'b0;
      pick = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            ptr <= 1'b0;
    else if (clk_enable) begin
      if (pin)                             ptr <= 1'b1;
      else if (take && (req == 2'b11))     ptr <= ~win;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single icemem port between the CPU (port 0) and the loader (port 1).
// Define MEM_ARB_LOCK_EN to add the loader 'lock' input for atomic multi-word loads.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_enable,
`ifdef MEM_ARB_LOCK_EN
  input  logic                lock,
`endif
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_read_address,
  output logic [ADDR_W-1:0]   mem_write_address,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_write_enable,
  input  logic [DATA_W-1:0]   mem_read_data
);
  localparam logic [1:0] LAT = 2'(READ_LAT);

  arb_state_t        state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic              owner, owner_nx;
  logic [1:0]        gnt_nx, rvalid_nx;
  logic              we_nx;
  logic [DATA_W-1:0] rdata_nx, wd_nx;
  logic [ADDR_W-1:0] ra_nx, wa_nx;

  logic       block, idle_ok, take, pin, win;
  logic [1:0] req_m, pick;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_LOCK_EN
  assign block = lock && (owner == 1'(PORT_LDR));
`else
  assign block = 1'b0;
`endif

  // No grant while a grant pulse is still showing: the requester has not yet
  // had an enabled cycle to see it and drop or change its request.
  assign req_m   = {req[PORT_LDR], req[PORT_CPU] & ~block};
  assign idle_ok = (state == IDLE) && (gnt == 2'b00);
  assign take    = idle_ok && (req_m != 2'b00);
  assign pin     = (state == IDLE) && block;

  rr_pick2 u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .req        (req_m),
    .take       (take),
    .pin        (pin),
    .pick       (pick),
    .win        (win)
  );

  assign sel_addr  = win ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
  assign sel_wdata = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    owner_nx  = owner;
    gnt_nx    = 2'b00;
    rvalid_nx = 2'b00;
    we_nx     = 1'b0;
    rdata_nx  = rdata;
    ra_nx     = mem_read_address;
    wa_nx     = mem_write_address;
    wd_nx     = mem_write_data;
    case (state)
      IDLE: begin
        if (take) begin
          gnt_nx   = pick;
          owner_nx = win;
          if (we[win]) begin
            we_nx = 1'b1;
            wa_nx = sel_addr;
            wd_nx = sel_wdata;
          end else begin
            ra_nx    = sel_addr;
            cnt_nx   = LAT;
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          rdata_nx  = mem_read_data;
          rvalid_nx = owner ? 2'b10 : 2'b01;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= 2'd0;
      owner             <= 1'b0;
      gnt               <= 2'b00;
      rvalid            <= 2'b00;
      rdata             <= '0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_write_enable  <= 1'b0;
    end else if (clk_enable) begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      owner             <= owner_nx;
      gnt               <= gnt_nx;
      rvalid            <= rvalid_nx;
      rdata             <= rdata_nx;
      mem_read_address  <= ra_nx;
      mem_write_address <= wa_nx;
      mem_write_data    <= wd_nx;
      mem_write_enable  <= we_nx;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small clock-enabled icemem model.
// Lock scenario is included when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk, rst_n, clk_enable;
`ifdef MEM_ARB_LOCK_EN
  logic          lock;
`endif
  logic [1:0]    req, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata, mem_write_data, mem_read_data;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic          mem_write_enable;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clk_enable        (clk_enable),
`ifdef MEM_ARB_LOCK_EN
    .lock              (lock),
`endif
    .req               (req),
    .we                (we),
    .addr              (addr),
    .wdata             (wdata),
    .gnt               (gnt),
    .rvalid            (rvalid),
    .rdata             (rdata),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .mem_read_data     (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // icemem model: one enabled cycle from read address to output_data
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_rd;
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (clk_enable) begin
      if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
      mem_rd <= mem[mem_read_address];
    end
  end
  assign mem_read_data = mem_rd;

  task automatic clk1(input logic en);
    clk_enable = en;
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    clk_enable = 1'b0;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; we = 2'b00; clk_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    clk_enable = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
`ifdef MEM_ARB_LOCK_EN
    lock = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, rvalid, mem_write_enable} !== 5'b0) begin
      failures++; $display("FAIL reset_pulses got %b exp 00000", {gnt, rvalid, mem_write_enable});
    end
    checks++;
    if ({rdata, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
      failures++; $display("FAIL reset_data got %h exp 0", {rdata, mem_read_address, mem_write_address, mem_write_data});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    preload(8'h10, 32'hDEADBEEF);
    req = 2'b01; we = 2'b00; addr = {8'h00, 8'h10};
    clk1(1'b1);
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL cpu_read_gnt got %b exp 01", gnt); end
    checks++;
    if (mem_read_address !== 8'h10) begin failures++; $display("FAIL cpu_read_addr got %h exp 10", mem_read_address); end
    req = 2'b00;
    clk1(1'b1);
    checks++;
    if ({gnt, rvalid} !== 4'b0000) begin failures++; $display("FAIL cpu_read_gap got %b exp 0000", {gnt, rvalid}); end
    clk1(1'b1);
    checks++;
    if (rvalid !== 2'b01) begin failures++; $display("FAIL cpu_read_rvalid got %b exp 01", rvalid); end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_read_rdata got %h exp deadbeef", rdata); end
    clk1(1'b1);
    checks++;
    if (rvalid !== 2'b00) begin failures++; $display("FAIL cpu_read_rvalid_end got %b exp 00", rvalid); end
  endtask

  task automatic test_write_then_read();
    req = 2'b10; we = 2'b10; addr = {8'h20, 8'h00}; wdata = {32'h0000CAFE, 32'h0};
    clk1(1'b1);
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL wr_gnt got %b exp 10", gnt); end
    checks++;
    if ({mem_write_enable, mem_write_address, mem_write_data} !== {1'b1, 8'h20, 32'h0000CAFE}) begin
      failures++; $display("FAIL wr_cmd got %h exp 1200000cafe", {mem_write_enable, mem_write_address, mem_write_data});
    end
    req = 2'b00; we = 2'b00;
    clk1(1'b1);
    checks++;
    if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL wr_strobe_end got %b exp 0", mem_write_enable); end
    req = 2'b01; addr = {8'h00, 8'h20};
    clk1(1'b1);
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL rd_after_wr_gnt got %b exp 01", gnt); end
    req = 2'b00;
    clk1(1'b1);
    clk1(1'b1);
    checks++;
    if ({rvalid, rdata} !== {2'b01, 32'h0000CAFE}) begin
      failures++; $display("FAIL rd_after_wr got %b/%h exp 01/0000cafe", rvalid, rdata);
    end
    clk1(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    do_reset();
    req = 2'b11; we = 2'b11; addr = {8'h41, 8'h40}; wdata = {32'h2, 32'h1};
    for (int i = 0; i < 12; i++) begin
      clk1(1'b1);
      exp = (i % 2 != 0) ? 2'b00 : (((i / 2) % 2 != 0) ? 2'b10 : 2'b01);
      checks++;
      if (gnt !== exp) begin failures++; $display("FAIL rr_seq[%0d] got %b exp %b", i, gnt, exp); end
    end
    req = 2'b00; we = 2'b00;
    clk1(1'b1);
  endtask

  task automatic test_clk_div4();
    int g_first, r_first, g_cnt, r_cnt;
    logic [DW-1:0] rd_seen;
    g_first = -1; r_first = -1; g_cnt = 0; r_cnt = 0; rd_seen = '0;
    req = 2'b01; we = 2'b00; addr = {8'h00, 8'h10};
    for (int i = 0; i < 16; i++) begin
      clk1((i % 4) == 0);
      if (gnt[0]) begin g_cnt++; if (g_first < 0) g_first = i; req = 2'b00; end
      if (rvalid[0]) begin r_cnt++; if (r_first < 0) r_first = i; rd_seen = rdata; end
    end
    checks++;
    if (g_cnt != 4) begin failures++; $display("FAIL div4_gnt_width got %0d exp 4", g_cnt); end
    checks++;
    if (r_cnt != 4) begin failures++; $display("FAIL div4_rvalid_width got %0d exp 4", r_cnt); end
    checks++;
    if (g_first != 0 || r_first != 8) begin
      failures++; $display("FAIL div4_latency got gnt@%0d rvalid@%0d exp gnt@0 rvalid@8", g_first, r_first);
    end
    checks++;
    if (rd_seen !== 32'hDEADBEEF) begin failures++; $display("FAIL div4_rdata got %h exp deadbeef", rd_seen); end
  endtask

  task automatic test_reset_mid_txn();
    logic seen;
    req = 2'b10; we = 2'b10; addr = {8'h50, 8'h00}; wdata = {32'h55, 32'h0};
    clk1(1'b1);
    req = 2'b00; we = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL rst_wr_strobe got %b exp 0", mem_write_enable); end
    @(negedge clk); rst_n = 1'b1;
    req = 2'b01; we = 2'b00; addr = {8'h00, 8'h10};
    clk1(1'b1);
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL rst_mid_gnt got %b exp 01", gnt); end
    req = 2'b00;
    clk1(1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rvalid, mem_write_enable, rdata, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got nonzero (raddr %h rdata %h) exp 0", mem_read_address, rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk1(1'b1);
      if (rvalid !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rvalid got 1 exp 0"); end
    req = 2'b11; we = 2'b00; addr = {8'h20, 8'h10};
    clk1(1'b1);
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL rst_first_rr got %b exp 01", gnt); end
    req = 2'b00;
    repeat (3) clk1(1'b1);
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp [0:8];
    exp = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    do_reset();
    lock = 1'b1;
    req = 2'b10; we = 2'b10; addr = {8'h30, 8'h10}; wdata = {32'h1, 32'h0};
    for (int i = 0; i < 9; i++) begin
      if (i == 8) lock = 1'b0;
      clk1(1'b1);
      checks++;
      if (gnt !== exp[i]) begin failures++; $display("FAIL lock_seq[%0d] got %b exp %b", i, gnt, exp[i]); end
      if (i == 0) req = 2'b11;
      if (i == 4) begin req = 2'b01; we = 2'b00; end
      if (i == 8) req = 2'b00;
    end
    repeat (3) clk1(1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
    test_write_then_read();
    test_back_to_back();
    test_clk_div4();
    test_reset_mid_txn();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single icemem read/write port between two requesters:
  - port 0: the pipelined CPU data/instruction path;
  - port 1: a debug/boot loader that fills or inspects memory.
- Sits between the requesters and icemem, in the same clk domain.
- Advances only on clk_enable strobes from clock_div.
- Round-robin arbitration with a request/grant handshake and a fixed read-return latency.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, memory data width.
- READ_LAT, 1, enabled cycles from issue to valid icemem output_data; legal range 1..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  qualifying strobe; all state advances only when high.
- req  in  2  per-port request; bit0 = CPU, bit1 = loader.
- we  in  2  per-port write flag, sampled with req.
- addr  in  2*ADDR_W  per-port address; port n uses bits [n*ADDR_W +: ADDR_W].
- wdata  in  2*DATA_W  per-port write data.
- gnt  out  2  one-enabled-cycle grant pulse, one-hot or zero.
- rvalid  out  2  one-enabled-cycle read-data-valid pulse.
- rdata  out  DATA_W  read data, shared; qualified by rvalid.
- mem_read_address  out  ADDR_W  to icemem read_address.
- mem_write_address  out  ADDR_W  to icemem write_address.
- mem_write_data  out  DATA_W  to icemem write_data.
- mem_write_enable  out  1  to icemem write_enable.
- mem_read_data  in  DATA_W  from icemem output_data.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; rr_ptr = 0 (CPU favoured first); wait counter = 0.
  - gnt, rvalid, mem_write_enable = 0.
  - rdata, mem_read_address, mem_write_address, mem_write_data = 0.
- Enabled cycle: a clk edge with clk_enable = 1. With clk_enable = 0 all registers hold and pulse outputs hold their value, so a pulse stays high until the next enabled cycle.
- Requester rule: once req[n] is raised, req[n], we[n], addr and wdata stay stable until the enabled cycle where gnt[n] = 1. Dropping req before grant is legal: the request is withdrawn and nothing is issued.
- FSM:
  - IDLE:
    - No req bits set: stay in IDLE, all pulses 0.
    - One bit set: grant that port.
    - Both set: grant port rr_ptr, then rr_ptr <= ~winner.
    - On grant: register the command onto the mem_* outputs and pulse gnt[w] for one enabled cycle.
    - Write: mem_write_enable = 1 for exactly that enabled cycle; next state IDLE. Back-to-back writes give one grant per 2 enabled cycles.
    - Read: load wait counter = READ_LAT; next state RD_WAIT.
  - RD_WAIT:
    - Decrement the counter each enabled cycle; mem_write_enable held 0.
    - At zero: capture mem_read_data into rdata, pulse rvalid[w], go to IDLE.
    - Read latency from gnt to rvalid = READ_LAT + 1 enabled cycles.
    - New requests are not granted until the state returns to IDLE.
- Ordering and conflicts:
  - Only one transaction is outstanding at a time, so reads always see completed prior writes.
  - Simultaneous request from both ports alternates strictly; neither port is starved beyond one transaction.
- Reset mid-transaction: any in-flight read is dropped with no rvalid, and the write strobe is deasserted immediately (async).

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds an input port lock, 1 bit, from the loader.
  - While lock = 1 and the loader holds the last grant, the CPU is not granted and rr_ptr stays pinned to the loader. This allows atomic multi-word boot loads.
  - Lock is sampled only in IDLE.
  - Lock without a pending loader req still blocks the CPU.
- Not defined: no lock port; pure round-robin.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE = 0, RD_WAIT = 1;
  - port index constants PORT_CPU = 0, PORT_LDR = 1;
  - ADDR_W / DATA_W defaults, shared with icemem.
- One sub-module, rr_pick2: combinational 2-way round-robin picker with registered pointer update. It is natural for reuse if a third requester is added.

Test Plan:
- CPU read alone, READ_LAT = 1:
  - Stimulus: req = 01, we = 0, addr0 = 0x10, memory[0x10] = 0xDEADBEEF.
  - Response: gnt = 01 on the next enabled cycle, then rvalid = 01 with rdata = 0xDEADBEEF 2 enabled cycles after gnt.
- Loader write then CPU read of the same address:
  - Stimulus: loader writes 0x0000CAFE to 0x20, then the CPU reads 0x20.
  - Response: mem_write_enable is a single enabled-cycle pulse, and the CPU reads 0x0000CAFE.
- Both requesting continuously for 6 grants:
  - Response: gnt sequence 01, 10, 01, 10, 01, 10 (after reset); no port waits more than one transaction.
- clk_enable divided by 4:
  - Stimulus: CPU read.
  - Response: gnt and rvalid each stay high exactly 4 clk edges; latency is counted in enabled cycles only.
- rst_n asserted during RD_WAIT:
  - Response: all outputs go to 0 immediately and no rvalid follows.
  - After release, the first grant goes to the CPU on contention.
- With MEM_ARB_LOCK_EN:
  - Stimulus: loader holds lock = 1 and issues 3 writes while the CPU requests.
  - Response: the CPU gets no grant until lock = 0, then is granted on the next IDLE.
